// File: rtl/coproc_pkg.sv
// Shared definitions for the coprocessor memory-port arbiter.
//   arb_state_t : arbiter state encoding (IDLE = no owner, OWNED = one owner)
//   ARB_FIXED / ARB_RR : arbitration mode selectors for RR_MODE
//   clog2       : ceiling log2, used to size index and counter fields
package coproc_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_OWNED = 1'b1
    } arb_state_t;

    localparam int ARB_FIXED = 0;
    localparam int ARB_RR    = 1;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v      = value - 1;
        while (v > 0) begin
            result = result + 1;
            v      = v >> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Bundle of requester-side and memory-side signals of the shared-memory arbiter.
//   master : the processor array (drives requests, sees grants and read-valid)
//   slave  : the arbiter itself (consumes requests, drives grants and memory port)
// Requester i occupies slice i of the flattened address and write-data buses.
interface mem_port_arbiter_if
    import coproc_pkg::*;
#(
    parameter int NUMBER_OF_PROCESSORS = 4,
    parameter int WORD_SIZE            = 32,
    parameter int ADDR_WIDTH           = 10
) ();
    localparam int N  = NUMBER_OF_PROCESSORS;
    localparam int IW = clog2(NUMBER_OF_PROCESSORS);

    logic [N-1:0]              Requests;
    logic [N-1:0]              Locks;
    logic [N*ADDR_WIDTH-1:0]   Req_Address;
    logic [N*WORD_SIZE-1:0]    Req_Write_Data;
    logic [N-1:0]              Req_Read_Enable;
    logic [N-1:0]              Req_Write_Enable;

    logic [N-1:0]              Grants;
    logic [IW-1:0]             Grant_Index;
    logic [N-1:0]              Read_Valid;

    logic [ADDR_WIDTH-1:0]     Memory_Address;
    logic [WORD_SIZE-1:0]      Memory_Write_Data;
    logic                      Memory_Read_Enable;
    logic                      Memory_Write_Enable;

    modport master (
        output Requests, Locks, Req_Address, Req_Write_Data, Req_Read_Enable, Req_Write_Enable,
        input  Grants, Grant_Index, Read_Valid,
        input  Memory_Address, Memory_Write_Data, Memory_Read_Enable, Memory_Write_Enable
    );

    modport slave (
        input  Requests, Locks, Req_Address, Req_Write_Data, Req_Read_Enable, Req_Write_Enable,
        output Grants, Grant_Index, Read_Valid,
        output Memory_Address, Memory_Write_Data, Memory_Read_Enable, Memory_Write_Enable
    );
endinterface

// File: rtl/mem_port_arbiter_rr_priority_pick.sv
// rr_priority_pick: combinational circular priority search.
//   req    : request vector
//   start  : index that has highest priority; search wraps past N-1 to 0
//   winner : one-hot first requester found (zero if none)
//   found  : at least one requester was present
// Fixed priority is obtained by tying start to 0.
module rr_priority_pick
    import coproc_pkg::*;
#(
    parameter int N  = 4,
    parameter int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] start,
    output logic [N-1:0]  winner,
    output logic          found
);
    always_comb begin
        int            pos;
        logic [IW-1:0] idx;
        winner = '0;
        found  = 1'b0;
        pos    = 0;
        idx    = '0;
        for (int off = 0; off < N; off++) begin
            pos = int'(start) + off;
            if (pos >= N) begin
                pos = pos - N;
            end
            idx = IW'(pos);
            if (!found && req[idx]) begin
                winner[idx] = 1'b1;
                found       = 1'b1;
            end
        end
    end
endmodule

// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: grants one single-port memory to one of N requesters.
//   clk, reset : single clock, synchronous active-high reset
//   bus        : requester inputs (Requests, Locks, per-slice address/data/enables),
//                grant outputs (Grants, Grant_Index, Read_Valid) and the muxed
//                memory port (Memory_Address/Write_Data/Read_Enable/Write_Enable)
// Ownership lasts until the owner drops its request or its burst budget runs
// out with its lock clear; the next owner is chosen on that same edge.
module mem_port_arbiter
    import coproc_pkg::*;
#(
    parameter int NUMBER_OF_PROCESSORS = 4,
    parameter int WORD_SIZE            = 32,
    parameter int ADDR_WIDTH           = 10,
    parameter int MAX_BURST            = 8,
    parameter int RR_MODE              = ARB_RR
) (
    input  logic              clk,
    input  logic              reset,
    mem_port_arbiter_if.slave bus
);
    localparam int N  = NUMBER_OF_PROCESSORS;
    localparam int IW = clog2(N);
    localparam int BW = (clog2(MAX_BURST) < 1) ? 1 : clog2(MAX_BURST);
    localparam logic [BW-1:0] BURST_LAST = BW'(MAX_BURST - 1);

    arb_state_t    state_q, state_d;
    logic [IW-1:0] owner_q, owner_d;
    logic [BW-1:0] burst_q, burst_d;
    logic [IW-1:0] ptr_q, ptr_d;
    logic [N-1:0]  grants_q, grants_d;
    logic [N-1:0]  rvalid_q, rvalid_d;

    logic          owner_req;
    logic          owner_lock;
    logic          burst_done;
    logic          expiry;
    logic [N-1:0]  pick_req;
    logic [IW-1:0] pick_start;
    logic [N-1:0]  pick_onehot;
    logic          pick_found;
    logic [IW-1:0] pick_idx;
    logic          do_grant;
    logic [IW-1:0] grant_idx;

    assign owner_req  = bus.Requests[owner_q];
    assign owner_lock = bus.Locks[owner_q];
    assign burst_done = (burst_q == BURST_LAST);
    assign expiry     = (state_q == ST_OWNED) && owner_req && burst_done && !owner_lock;

    // In round-robin mode an expired owner steps aside so others get a turn;
    // in fixed mode it competes normally, so a lower index always keeps winning.
    always_comb begin
        pick_req = bus.Requests;
        if (RR_MODE == ARB_RR && expiry) begin
            pick_req[owner_q] = 1'b0;
        end
        if (RR_MODE == ARB_RR) begin
            pick_start = (ptr_q == IW'(N - 1)) ? '0 : ptr_q + 1'b1;
        end else begin
            pick_start = '0;
        end
    end

    rr_priority_pick #(.N(N), .IW(IW)) u_pick (
        .req    (pick_req),
        .start  (pick_start),
        .winner (pick_onehot),
        .found  (pick_found)
    );

    always_comb begin
        pick_idx = '0;
        for (int i = 0; i < N; i++) begin
            if (pick_onehot[i]) begin
                pick_idx = IW'(i);
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        burst_d   = burst_q;
        ptr_d     = ptr_q;
        grants_d  = grants_q;
        do_grant  = 1'b0;
        grant_idx = pick_idx;
        case (state_q)
            ST_IDLE: begin
                do_grant = pick_found;
            end
            ST_OWNED: begin
                if (!owner_req) begin
                    if (pick_found) begin
                        do_grant = 1'b1;
                    end else begin
                        state_d  = ST_IDLE;
                        owner_d  = '0;
                        burst_d  = '0;
                        grants_d = '0;
                    end
                end else if (expiry) begin
                    // Nobody else waiting: the owner is re-granted with a fresh budget.
                    do_grant  = 1'b1;
                    grant_idx = pick_found ? pick_idx : owner_q;
                end else if (!owner_lock && !burst_done) begin
                    burst_d = burst_q + 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
        if (do_grant) begin
            state_d             = ST_OWNED;
            owner_d             = grant_idx;
            burst_d             = '0;
            ptr_d               = grant_idx;
            grants_d            = '0;
            grants_d[grant_idx] = 1'b1;
        end
    end

    // The memory answers one cycle after the enable, so read-valid is the
    // granted read enable delayed by one edge.
    for (genvar gi = 0; gi < N; gi++) begin : g_rvalid
        assign rvalid_d[gi] = grants_q[gi] & bus.Req_Read_Enable[gi];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            owner_q  <= '0;
            burst_q  <= '0;
            ptr_q    <= IW'(N - 1);
            grants_q <= '0;
            rvalid_q <= '0;
        end else begin
            state_q  <= state_d;
            owner_q  <= owner_d;
            burst_q  <= burst_d;
            ptr_q    <= ptr_d;
            grants_q <= grants_d;
            rvalid_q <= rvalid_d;
        end
    end

    // owner_q is held at 0 whenever idle, so it doubles as the idle mux select.
    assign bus.Grants              = grants_q;
    assign bus.Grant_Index         = owner_q;
    assign bus.Read_Valid          = rvalid_q;
    assign bus.Memory_Address      = bus.Req_Address[int'(owner_q) * ADDR_WIDTH +: ADDR_WIDTH];
    assign bus.Memory_Write_Data   = bus.Req_Write_Data[int'(owner_q) * WORD_SIZE +: WORD_SIZE];
    assign bus.Memory_Read_Enable  = (state_q == ST_OWNED) & bus.Req_Read_Enable[owner_q];
    assign bus.Memory_Write_Enable = (state_q == ST_OWNED) & bus.Req_Write_Enable[owner_q];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: one round-robin instance (MAX_BURST=2)
// and one fixed-priority instance (MAX_BURST=3) receive identical stimulus.
// The driver advances an abstract ownership model per instance and queues the
// expected outputs; a monitor pops and compares on each falling edge.
module tb_mem_port_arbiter;
    localparam int N  = 4;
    localparam int AW = 10;
    localparam int DW = 32;

    typedef struct {
        logic [3:0]  grants;
        logic [1:0]  idx;
        logic [3:0]  rv;
        logic [9:0]  addr;
        logic [31:0] wdata;
        logic        re;
        logic        we;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset_s = 1'b1;
    logic [3:0]    req_s = '0, lock_s = '0, rde_s = '0, wre_s = '0;
    logic [AW-1:0] addr_s [N];
    logic [DW-1:0] wdata_s [N];
    logic [N*AW-1:0] addr_flat;
    logic [N*DW-1:0] wdata_flat;
    bit            rand_data = 1'b1;

    always_comb begin
        addr_flat  = '0;
        wdata_flat = '0;
        for (int i = 0; i < N; i++) begin
            addr_flat[i*AW +: AW]  = addr_s[i];
            wdata_flat[i*DW +: DW] = wdata_s[i];
        end
    end

    mem_port_arbiter_if #(.NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW), .ADDR_WIDTH(AW)) bus_rr ();
    mem_port_arbiter_if #(.NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW), .ADDR_WIDTH(AW)) bus_fx ();

    assign bus_rr.Requests = req_s;          assign bus_fx.Requests = req_s;
    assign bus_rr.Locks = lock_s;            assign bus_fx.Locks = lock_s;
    assign bus_rr.Req_Address = addr_flat;   assign bus_fx.Req_Address = addr_flat;
    assign bus_rr.Req_Write_Data = wdata_flat; assign bus_fx.Req_Write_Data = wdata_flat;
    assign bus_rr.Req_Read_Enable = rde_s;   assign bus_fx.Req_Read_Enable = rde_s;
    assign bus_rr.Req_Write_Enable = wre_s;  assign bus_fx.Req_Write_Enable = wre_s;

    mem_port_arbiter #(.NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW), .ADDR_WIDTH(AW),
                       .MAX_BURST(2), .RR_MODE(1)) dut_rr (
        .clk(clk), .reset(reset_s), .bus(bus_rr));
    mem_port_arbiter #(.NUMBER_OF_PROCESSORS(N), .WORD_SIZE(DW), .ADDR_WIDTH(AW),
                       .MAX_BURST(3), .RR_MODE(0)) dut_fx (
        .clk(clk), .reset(reset_s), .bus(bus_fx));

    // Abstract model: index 0 = round-robin instance, index 1 = fixed instance.
    int         m_owned [2];
    int         m_owner [2];
    int         m_used  [2];   // owned cycles already counted toward the burst budget
    int         m_last  [2];
    logic [3:0] m_rv    [2];
    exp_t       q_exp   [2][$];

    int compared = 0;
    int mismatched = 0;

    task automatic model_step(input int m, input bit rr, input int maxb);
        int  exclude, winner, start, i;
        bit  arb;
        if (reset_s) begin
            m_owned[m] = 0; m_owner[m] = 0; m_used[m] = 0; m_last[m] = N - 1; m_rv[m] = '0;
            return;
        end
        m_rv[m] = '0;
        if (m_owned[m] != 0 && rde_s[m_owner[m]]) m_rv[m][m_owner[m]] = 1'b1;
        arb = 0;
        exclude = -1;
        if (m_owned[m] == 0 || !req_s[m_owner[m]]) begin
            arb = 1;
        end else if (m_used[m] == maxb - 1 && !lock_s[m_owner[m]]) begin
            arb = 1;
            if (rr) exclude = m_owner[m];
        end else if (!lock_s[m_owner[m]] && m_used[m] < maxb - 1) begin
            m_used[m]++;
        end
        if (!arb) return;
        start  = rr ? (m_last[m] + 1) % N : 0;
        winner = -1;
        for (int k = 0; k < N; k++) begin
            i = (start + k) % N;
            if (winner < 0 && req_s[i] && i != exclude) winner = i;
        end
        if (winner < 0 && exclude >= 0) winner = exclude;
        if (winner >= 0) begin
            m_owned[m] = 1; m_owner[m] = winner; m_used[m] = 0; m_last[m] = winner;
        end else begin
            m_owned[m] = 0; m_owner[m] = 0; m_used[m] = 0;
        end
    endtask

    function automatic exp_t model_out(input int m);
        exp_t e;
        int   o;
        o = m_owner[m];
        e.grants = (m_owned[m] != 0) ? 4'(1 << o) : 4'b0;
        e.idx    = 2'(o);
        e.rv     = m_rv[m];
        e.addr   = addr_s[o];
        e.wdata  = wdata_s[o];
        e.re     = (m_owned[m] != 0) && rde_s[o];
        e.we     = (m_owned[m] != 0) && wre_s[o];
        return e;
    endfunction

    // One clock: advance models with the inputs the edge sampled, then apply new inputs.
    task automatic cycle(input logic r, input logic [3:0] rq, input logic [3:0] lk,
                         input logic [3:0] rd, input logic [3:0] wr);
        @(posedge clk);
        #1;
        model_step(0, 1'b1, 2);
        model_step(1, 1'b0, 3);
        reset_s = r; req_s = rq; lock_s = lk; rde_s = rd; wre_s = wr;
        if (rand_data) begin
            for (int i = 0; i < N; i++) begin
                addr_s[i]  = AW'($urandom());
                wdata_s[i] = $urandom();
            end
        end
        q_exp[0].push_back(model_out(0));
        q_exp[1].push_back(model_out(1));
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        compared++;
        if (act !== req) begin
            mismatched++;
            $display("FAIL %s t=%0t got=%0h expected=%0h", name, $time, act, req);
        end
    endtask

    // Monitor: compares whatever is queued against the live outputs.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q_exp[0].size() > 0) begin
                e = q_exp[0].pop_front();
                chk("rr.grants", 64'(bus_rr.Grants), 64'(e.grants));
                chk("rr.onehot", 64'($onehot0(bus_rr.Grants)), 64'(1));
                chk("rr.index", 64'(bus_rr.Grant_Index), 64'(e.idx));
                chk("rr.read_valid", 64'(bus_rr.Read_Valid), 64'(e.rv));
                chk("rr.mem_addr", 64'(bus_rr.Memory_Address), 64'(e.addr));
                chk("rr.mem_wdata", 64'(bus_rr.Memory_Write_Data), 64'(e.wdata));
                chk("rr.mem_re", 64'(bus_rr.Memory_Read_Enable), 64'(e.re));
                chk("rr.mem_we", 64'(bus_rr.Memory_Write_Enable), 64'(e.we));
                $display("rr req=%b lk=%b grants=%b idx=%0d rv=%b", req_s, lock_s,
                         bus_rr.Grants, bus_rr.Grant_Index, bus_rr.Read_Valid);
            end
            if (q_exp[1].size() > 0) begin
                e = q_exp[1].pop_front();
                chk("fx.grants", 64'(bus_fx.Grants), 64'(e.grants));
                chk("fx.onehot", 64'($onehot0(bus_fx.Grants)), 64'(1));
                chk("fx.index", 64'(bus_fx.Grant_Index), 64'(e.idx));
                chk("fx.read_valid", 64'(bus_fx.Read_Valid), 64'(e.rv));
                chk("fx.mem_addr", 64'(bus_fx.Memory_Address), 64'(e.addr));
                chk("fx.mem_wdata", 64'(bus_fx.Memory_Write_Data), 64'(e.wdata));
                chk("fx.mem_re", 64'(bus_fx.Memory_Read_Enable), 64'(e.re));
                chk("fx.mem_we", 64'(bus_fx.Memory_Write_Enable), 64'(e.we));
            end
        end
    end

    initial begin
        logic [3:0] rq;
        for (int i = 0; i < N; i++) begin
            addr_s[i]  = '0;
            wdata_s[i] = '0;
        end
        for (int i = 0; i < 2; i++) begin
            m_owned[i] = 0; m_owner[i] = 0; m_used[i] = 0; m_last[i] = N - 1; m_rv[i] = '0;
        end
        // Reset, then all four requesting: round-robin rotates every two cycles.
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (12) cycle(1'b0, 4'hF, 4'h0, 4'h0, 4'h0);
        // Requesters 1 and 3 held.
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (12) cycle(1'b0, 4'b1010, 4'h0, 4'h0, 4'h0);
        // Locked owner 2, then requester 0 joins, then the lock drops.
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (20) cycle(1'b0, 4'b0100, 4'b0100, 4'h0, 4'h0);
        repeat (4) cycle(1'b0, 4'b0101, 4'b0100, 4'h0, 4'h0);
        repeat (8) cycle(1'b0, 4'b0101, 4'b0000, 4'h0, 4'h0);
        // Requester 1 reads 0x3A5.
        rand_data = 1'b0;
        addr_s[1] = 10'h3A5;
        wdata_s[3] = 32'hDEADBEEF;
        cycle(1'b1, 4'h0, 4'h0, 4'h0, 4'h0);
        repeat (4) cycle(1'b0, 4'b0010, 4'h0, 4'b0010, 4'h0);
        // Reset while requester 3 is writing and reading, then two requesters.
        repeat (3) cycle(1'b0, 4'b1000, 4'h0, 4'b1000, 4'b1000);
        cycle(1'b1, 4'b1000, 4'h0, 4'b1000, 4'b1000);
        repeat (3) cycle(1'b0, 4'b1001, 4'h0, 4'h0, 4'b1001);
        // Owner drops as another raises; then everyone leaves.
        cycle(1'b0, 4'b0001, 4'h0, 4'h0, 4'h0);
        repeat (3) cycle(1'b0, 4'b0010, 4'h0, 4'h0, 4'h0);
        repeat (2) cycle(1'b0, 4'b0000, 4'h0, 4'h0, 4'h0);
        // Randomised traffic with persistent requests, rare locks and resets.
        rand_data = 1'b1;
        rq = 4'h0;
        repeat (1500) begin
            rq = rq ^ (4'($urandom()) & 4'($urandom()));
            cycle(($urandom_range(0, 59) == 0), rq,
                  4'($urandom()) & 4'($urandom()) & 4'($urandom()),
                  4'($urandom()), 4'($urandom()));
        end
        repeat (2) @(negedge clk);
        chk("rr.queue_drained", 64'(q_exp[0].size()), 64'(0));
        chk("fx.queue_drained", 64'(q_exp[1].size()), 64'(0));
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
